lc_dco_bias_cal: RTL and testbench
==================================

// Module: lc_dco_bias_cal
// PURPOSE
//  Digital driver for the LC-DCO tail-current mirror. Runs a SAR search over a thermometer-coded
//  Ibias DAC (unit mirror legs into the cross-coupled pair's bias node), using an analog
//  amplitude comparator. Finds the largest code at which oscillation amplitude stays below target.
//  Sits between the top-level DCO controller (start/done) and the analog bias DAC leg enables.
// PARAMETERS
//  DAC_BITS    5   binary code width; thermometer width THERM_W = 2**DAC_BITS-1 (localparam)
//  SETTLE_CYC  16  clk cycles waited after each trial code before sampling comparator (>=1)
//  AVG_N       4   comparator samples per bit decision, majority vote (>=1)
// PORTS
//  clk           in   1         system clock
//  reset         in   1         synchronous, active-high reset
//  start         in   1         1-cycle request to begin calibration (ignored while busy)
//  amp_high      in   1         async comparator: 1 = amplitude above target
//  ovr_en        in   1         manual override enable
//  ovr_code      in   DAC_BITS  manual code used while ovr_en=1
//  busy          out  1         calibration in progress
//  done          out  1         1-cycle pulse when calibration completes
//  code          out  DAC_BITS  current applied binary code
//  ibias_en      out  THERM_W   thermometer leg enables; bit i = (code > i)
// BEHAVIOUR
//  - Reset: state IDLE, code=0, ibias_en=0, busy=0, done=0, counters and synchronizer cleared.
//  - amp_high passes a 2-flop synchronizer; only the synchronized value is used.
//  - FSM: IDLE -> SETTLE -> SAMPLE -> DECIDE -> (SETTLE | FINISH) -> IDLE.
//    IDLE: start=1 and ovr_en=0 -> bit index k=DAC_BITS-1, code = 1<<k, busy=1 next cycle.
//    SETTLE: count SETTLE_CYC cycles with trial code applied.
//    SAMPLE: take AVG_N consecutive synchronized samples, counting highs.
//    DECIDE (1 cycle): highs*2 >= AVG_N (tie counts as high) -> clear bit k, else keep it;
//      if k>0: set bit k-1, k--, go to SETTLE; else go to FINISH.
//    FINISH (1 cycle): done=1, busy=0 next cycle, code held.
//  - Per-bit latency SETTLE_CYC+AVG_N+1 cycles; start-to-done = DAC_BITS*(SETTLE_CYC+AVG_N+1)+1.
//  - ibias_en is registered and updates in the same cycle as code (no extra lag).
//  - ovr_en=1: code=ovr_code on the next edge; any calibration in progress aborts to IDLE with
//    busy=0 and no done pulse; start ignored. ovr_en falling edge: code holds its last value.
//  - start while busy or in FINISH: ignored. start and ovr_en both high: ovr_en wins.
//  - reset mid-calibration: returns to reset values on the next edge; no done pulse.
//  - code never wraps; all trial codes are in [0, 2**DAC_BITS-1].
// CONFIGURATION
//  LC_DCO_BIAS_TRACK_EN defined: after FINISH, enter state TRACK (busy=0). Every
//    SETTLE_CYC+AVG_N cycles, apply the same majority rule: high -> code-1, low -> code+1.
//    Saturates at 0 and 2**DAC_BITS-1. start restarts the full SAR search; ovr_en exits to IDLE.
//  Not defined: no TRACK state; code is static after FINISH until start, ovr_en or reset.
// STRUCTURE
//  - Package lc_dco_pkg: state enum (IDLE, SETTLE, SAMPLE, DECIDE, FINISH, TRACK) and a
//    function bin2therm(code) -> THERM_W vector.
//  - Sub-module lc_dco_sync2: generic 2-flop synchronizer with synchronous reset, used for amp_high.
// TESTING  (DAC_BITS=5, SETTLE_CYC=16, AVG_N=4)
//  - Comparator model amp_high=(code>=19); pulse start -> trials 16,24,20,18,19; done after
//    5*21+1=106 cycles; code=18; ibias_en=31'h0003FFFF.
//  - amp_high tied 0 -> code=31, ibias_en all ones; tied 1 -> code=0, ibias_en=0.
//  - Alternating amp_high per sample (2 of 4 high) -> treated as high every bit -> code=0.
//  - Assert reset at cycle 50 of calibration -> next edge: busy=0, code=0, no done pulse ever.
//  - ovr_en=1, ovr_code=7 mid-calibration -> code=7, ibias_en=31'h7F, busy=0, no done;
//    start during override ignored.
//  - TRACK_EN: after converging to 18, change threshold to code>=22 -> code steps 19,20,21,22,
//    21,... one step every 20 cycles; threshold >31 -> code saturates at 31.

Source files
------------

// File: rtl/lc_dco_pkg.sv
// Shared types and helpers for the LC-DCO tail-current bias calibrator.
package lc_dco_pkg;

  // Widest DAC the thermometer helper supports.
  localparam int unsigned MaxDacBits = 8;
  localparam int unsigned MaxThermW  = 2**MaxDacBits - 1;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StDecide,
    StFinish,
    StTrack
  } cal_state_e;

  // Thermometer expansion: bit i is set when code > i. Callers truncate to their width.
  function automatic logic [MaxThermW-1:0] bin2therm(input logic [MaxDacBits-1:0] code);
    return ~({MaxThermW{1'b1}} << code);
  endfunction

endpackage

// File: rtl/lc_dco_sync2.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module lc_dco_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lc_dco_bias_cal.sv
// LC-DCO tail-current bias calibrator: SAR search over a thermometer-coded Ibias DAC driven by
// a synchronized amplitude comparator, with manual override.
// Optional build macro LC_DCO_BIAS_TRACK_EN adds a post-calibration +/-1 tracking loop.
module lc_dco_bias_cal
  import lc_dco_pkg::*;
#(
  parameter int unsigned DAC_BITS   = 5,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned AVG_N      = 4,
  localparam int unsigned THERM_W   = 2**DAC_BITS - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                amp_high,
  input  logic                ovr_en,
  input  logic [DAC_BITS-1:0] ovr_code,
  output logic                busy,
  output logic                done,
  output logic [DAC_BITS-1:0] code,
  output logic [THERM_W-1:0]  ibias_en
);

  localparam int unsigned KIdxW = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
  localparam int unsigned CntW  = $clog2(SETTLE_CYC + AVG_N + 1);
  localparam int unsigned HiW   = $clog2(AVG_N + 1);

  cal_state_e          state_q, state_d;
  logic [DAC_BITS-1:0] code_q, code_d;
  logic [THERM_W-1:0]  ibias_en_q, ibias_en_d;
  logic [KIdxW-1:0]    k_q, k_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [HiW-1:0]      highs_q, highs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                amp_sync;
  logic                launch;
  logic [31:0]         highs_x2;
  logic [DAC_BITS-1:0] trial;
`ifdef LC_DCO_BIAS_TRACK_EN
  localparam logic [DAC_BITS-1:0] CodeMax = '1;
  logic [HiW-1:0]      track_highs;
`endif

  lc_dco_sync2 #(
    .Width(1)
  ) u_amp_sync (
    .clk_i  (clk),
    .reset_i(reset),
    .d_i    (amp_high),
    .q_o    (amp_sync)
  );

  // Next-state logic for the search FSM, applied code and thermometer enables.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    highs_d  = highs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    trial    = code_q;
    highs_x2 = 32'(highs_q) << 1;
`ifdef LC_DCO_BIAS_TRACK_EN
    track_highs = highs_q + HiW'(amp_sync);
`endif
    // A new search may start from idle or from tracking; override always takes priority.
    launch = start && ((state_q == StIdle) || (state_q == StTrack));

    if (ovr_en) begin
      state_d = StIdle;
      code_d  = ovr_code;
      busy_d  = 1'b0;
      cnt_d   = '0;
      highs_d = '0;
    end else if (launch) begin
      state_d                = StSettle;
      k_d                    = KIdxW'(DAC_BITS - 1);
      code_d                 = '0;
      code_d[DAC_BITS-1]     = 1'b1;
      busy_d                 = 1'b1;
      cnt_d                  = '0;
      highs_d                = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
            cnt_d   = '0;
            state_d = StSample;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StSample: begin
          highs_d = highs_q + HiW'(amp_sync);
          if (cnt_q == CntW'(AVG_N - 1)) begin
            cnt_d   = '0;
            state_d = StDecide;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDecide: begin
          // Ties count as high: amplitude at or above target drops the trial bit.
          if (highs_x2 >= AVG_N) begin
            trial[k_q] = 1'b0;
          end
          highs_d = '0;
          if (k_q != '0) begin
            trial[k_q - 1'b1] = 1'b1;
            k_d               = k_q - 1'b1;
            state_d           = StSettle;
          end else begin
            state_d = StFinish;
            done_d  = 1'b1;
          end
          code_d = trial;
        end
        StFinish: begin
          busy_d = 1'b0;
`ifdef LC_DCO_BIAS_TRACK_EN
          state_d = StTrack;
          cnt_d   = '0;
          highs_d = '0;
`else
          state_d = StIdle;
`endif
        end
`ifdef LC_DCO_BIAS_TRACK_EN
        StTrack: begin
          // Settle for SETTLE_CYC, then vote over AVG_N samples and nudge by one code.
          if (cnt_q >= CntW'(SETTLE_CYC)) begin
            highs_d = track_highs;
          end
          if (cnt_q == CntW'(SETTLE_CYC + AVG_N - 1)) begin
            cnt_d   = '0;
            highs_d = '0;
            if ((32'(track_highs) << 1) >= AVG_N) begin
              if (code_q != '0) code_d = code_q - 1'b1;
            end else begin
              if (code_q != CodeMax) code_d = code_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end

    // Enables derive from the next code so they move on the same edge as code.
    ibias_en_d = THERM_W'(bin2therm(MaxDacBits'(code_d)));
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      code_q     <= '0;
      ibias_en_q <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      highs_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      ibias_en_q <= ibias_en_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      highs_q    <= highs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign code     = code_q;
  assign ibias_en = ibias_en_q;

endmodule

// File: tb/tb_lc_dco_bias_cal.sv
// Scoreboard bench for lc_dco_bias_cal: stimulus pushes expected SAR trials and results,
// a monitor pops and compares them whenever the DUT moves a trial code or pulses done.
module tb_lc_dco_bias_cal;

  localparam int DacBits   = 5;
  localparam int SettleCyc = 16;
  localparam int AvgN      = 4;
  localparam int ExpLat    = DacBits * (SettleCyc + AvgN + 1) + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        amp_high;
  logic        ovr_en;
  logic [4:0]  ovr_code;
  logic        busy;
  logic        done;
  logic [4:0]  code;
  logic [30:0] ibias_en;

  typedef struct {
    int code;
    int lat;
  } exp_t;

  exp_t        exp_q[$];
  int          trial_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          amp_mode = 0;   // 0: threshold comparator, 1: alternating every clock
  int unsigned thr = 0;
  logic        alt = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) alt <= ~alt;

  assign amp_high = (amp_mode == 1) ? alt : (32'(code) >= thr);

  lc_dco_bias_cal #(
    .DAC_BITS  (DacBits),
    .SETTLE_CYC(SettleCyc),
    .AVG_N     (AvgN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .amp_high(amp_high),
    .ovr_en  (ovr_en),
    .ovr_code(ovr_code),
    .busy    (busy),
    .done    (done),
    .code    (code),
    .ibias_en(ibias_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // Comparator as seen by the search: 1 = amplitude at/above target for this code.
  function automatic bit amp_model(input int mode, input int unsigned t, input int c);
    if (mode == 1) return 1'b1;  // 2 of 4 high is a tie, which counts as high
    return c >= int'(t);
  endfunction

  // Largest code whose amplitude stays below target (0 if none).
  function automatic int best_code(input int mode, input int unsigned t);
    int best = 0;
    for (int c = 0; c < (1 << DacBits); c++) if (!amp_model(mode, t, c)) best = c;
    return best;
  endfunction

  function automatic logic [31:0] therm_ref(input int c);
    return 32'((64'd1 << c) - 64'd1);
  endfunction

  // Pushes the expected trial sequence and result, then pulses start.
  task automatic launch(input int mode, input int unsigned t);
    int   acc = 0;
    exp_t e;
    @(negedge clk);
    amp_mode = mode;
    thr      = t;
    for (int k = DacBits - 1; k >= 0; k--) begin
      int tr = acc | (1 << k);
      trial_q.push_back(tr);
      if (!amp_model(mode, t, tr)) acc = tr;
    end
    e.code = best_code(mode, t);
    e.lat  = ExpLat;
    exp_q.push_back(e);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_cal(input int mode, input int unsigned t);
    launch(mode, t);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fail_evt("done_timeout", 32'(exp_q.size()));
      exp_q.delete();
      trial_q.delete();
    end
  endtask

  // Monitor: compares trial codes and completion results against the scoreboard.
  logic busy_prev = 1'b0;
  logic [4:0] code_prev = '0;
  exp_t m_e;
  int   m_t;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      if (busy && !done && (!busy_prev || code != code_prev)) begin
        if (trial_q.size() == 0) fail_evt("unexpected_trial", 32'(code));
        else begin
          m_t = trial_q.pop_front();
          check("trial_code", 32'(code), 32'(m_t));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) fail_evt("unexpected_done", 32'(code));
        else begin
          m_e = exp_q.pop_front();
          check("done_code", 32'(code), 32'(m_e.code));
          check("done_ibias", 32'(ibias_en), therm_ref(m_e.code));
          check("done_latency", 32'(cyc - start_cyc), 32'(m_e.lat));
          check("trials_left", 32'(trial_q.size()), 32'd0);
        end
      end
    end
    busy_prev = busy;
    code_prev = code;
  end

  initial begin
    int dc;
    reset    = 1'b1;
    start    = 1'b0;
    ovr_en   = 1'b0;
    ovr_code = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_code", 32'(code), 32'd0);
    check("reset_ibias", 32'(ibias_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed: threshold 19 gives trials 16,24,20,18,19 and result 18.
    run_cal(0, 19);
    check("dir19_code", 32'(code), 32'd18);
    check("dir19_ibias", 32'(ibias_en), 32'h0003_FFFF);

`ifdef LC_DCO_BIAS_TRACK_EN
    begin
      int vals[$];
      int times[$];
      int m;
      logic [4:0] last;
      thr  = 22;
      last = code;
      for (int i = 0; i < 200 && vals.size() < 5; i++) begin
        @(negedge clk);
        if (code != last) begin
          vals.push_back(int'(code));
          times.push_back(cyc);
          last = code;
        end
      end
      check("track_steps", 32'(vals.size()), 32'd5);
      m = 18;
      for (int i = 0; i < vals.size(); i++) begin
        m = (m >= int'(thr)) ? m - 1 : m + 1;
        check("track_code", 32'(vals[i]), 32'(m));
        if (i > 0) check("track_period", 32'(times[i] - times[i-1]), 32'(SettleCyc + AvgN));
      end
      thr = 40;
      repeat (300) @(negedge clk);
      check("track_sat_code", 32'(code), 32'd31);
      check("track_sat_ibias", 32'(ibias_en), 32'h7FFF_FFFF);
    end
`endif

    run_cal(0, 1000);  // amp_high tied low
    check("tied0_ibias", 32'(ibias_en), 32'h7FFF_FFFF);
    run_cal(0, 0);     // amp_high tied high
    check("tied1_ibias", 32'(ibias_en), 32'd0);
    run_cal(1, 0);     // alternating samples
    check("alt_code", 32'(code), 32'd0);

    for (int i = 0; i < 6; i++) run_cal(0, $urandom_range(0, 32));

    // Reset mid-calibration.
    launch(0, 19);
    repeat (49) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    trial_q.delete();
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_code", 32'(code), 32'd0);
    check("midrst_ibias", 32'(ibias_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dc = done_cnt;
    repeat (150) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dc), 32'd0);

    // Override mid-calibration, with start pulsed during override.
    launch(0, 19);
    repeat (30) @(negedge clk);
    ovr_en   = 1'b1;
    ovr_code = 5'd7;
    exp_q.delete();
    trial_q.delete();
    dc = done_cnt;
    @(posedge clk);
    #1;
    check("ovr_code", 32'(code), 32'd7);
    check("ovr_ibias", 32'(ibias_en), 32'h7F);
    check("ovr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("ovr_start_ignored", 32'(busy), 32'd0);
    ovr_en = 1'b0;
    repeat (150) @(negedge clk);
    check("ovr_hold_code", 32'(code), 32'd7);
    check("ovr_hold_busy", 32'(busy), 32'd0);
    check("ovr_no_done", 32'(done_cnt - dc), 32'd0);

    run_cal(0, $urandom_range(1, 31));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
